// File: rtl/rgb_update_arbiter_pkg.sv
`default_nettype none
//============================================================================
// Module : rgb_pkg
// Brief  : Shared constants and types for the PL9823 update arbiter.
// Rev    : 1.0  initial release
//============================================================================
package rgb_pkg;

    localparam int         NUM_LEDS     = 3;
    localparam logic [1:0] IDX_BCAST    = 2'd3;
    localparam int         HOLD_DEFAULT = 9300;
    localparam int         CNT_W        = 14;

    typedef struct packed {
        logic [7:0] rot;
        logic [7:0] gruen;
        logic [7:0] blau;
    } colour_t;

    typedef enum logic [0:0] {
        ST_GRANT = 1'b0,
        ST_ACKS  = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rgb_update_arbiter_if.sv
`default_nettype none
//============================================================================
// Module : rgb_update_arbiter_if
// Brief  : Write handshake bundle for requesters A and B.
// Rev    : 1.0  initial release
//============================================================================
interface rgb_update_arbiter_if;
    import rgb_pkg::*;

    logic       A_REQ;
    logic [1:0] A_IDX;
    logic [7:0] A_ROT;
    logic [7:0] A_GRUEN;
    logic [7:0] A_BLAU;
    logic       A_COMMIT;
    logic       A_ACK;

    logic       B_REQ;
    logic [1:0] B_IDX;
    logic [7:0] B_ROT;
    logic [7:0] B_GRUEN;
    logic [7:0] B_BLAU;
    logic       B_COMMIT;
    logic       B_ACK;

    modport master (
        output A_REQ, A_IDX, A_ROT, A_GRUEN, A_BLAU, A_COMMIT,
        output B_REQ, B_IDX, B_ROT, B_GRUEN, B_BLAU, B_COMMIT,
        input  A_ACK, B_ACK
    );

    modport slave (
        input  A_REQ, A_IDX, A_ROT, A_GRUEN, A_BLAU, A_COMMIT,
        input  B_REQ, B_IDX, B_ROT, B_GRUEN, B_BLAU, B_COMMIT,
        output A_ACK, B_ACK
    );

endinterface
`default_nettype wire

// File: rtl/rgb_update_arbiter_rr_arb2.sv
`default_nettype none
//============================================================================
// Module : rr_arb2
// Brief  : Two-requester round-robin arbiter with a grant/ack FSM.
// Rev    : 1.0  initial release
//============================================================================
module rr_arb2
    import rgb_pkg::*;
(
    input  wire logic CLK,
    input  wire logic RST,
    input  wire logic i_req_a,
    input  wire logic i_req_b,
    output logic      o_gnt_a,
    output logic      o_gnt_b,
    output logic      o_ack_a,
    output logic      o_ack_b
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       r_last_b;
    logic       w_last_b_nxt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= ST_GRANT;
            r_last_b <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_last_b <= w_last_b_nxt;
        end
    end

    // Acks come only from registered state, so no input reaches them combinationally.
    always_comb begin
        w_state_nxt  = r_state;
        w_last_b_nxt = r_last_b;
        o_gnt_a      = 1'b0;
        o_gnt_b      = 1'b0;
        o_ack_a      = 1'b0;
        o_ack_b      = 1'b0;
        case (r_state)
            ST_GRANT: begin
                if (i_req_a && (!i_req_b || r_last_b)) begin
                    o_gnt_a      = 1'b1;
                    w_last_b_nxt = 1'b0;
                    w_state_nxt  = ST_ACKS;
                end else if (i_req_b) begin
                    o_gnt_b      = 1'b1;
                    w_last_b_nxt = 1'b1;
                    w_state_nxt  = ST_ACKS;
                end
            end
            ST_ACKS: begin
                o_ack_a     = ~r_last_b;
                o_ack_b     = r_last_b;
                w_state_nxt = ST_GRANT;
            end
            default: w_state_nxt = ST_GRANT;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rgb_update_arbiter.sv
`default_nettype none
//============================================================================
// Module : rgb_update_arbiter
// Brief  : Shadow colour buffer with rate-limited atomic commit to 3 LEDs.
// Rev    : 1.0  initial release
//============================================================================
module rgb_update_arbiter
    import rgb_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_DEFAULT
)(
    input  wire logic           CLK,
    input  wire logic           RST,
    rgb_update_arbiter_if.slave host,
    output logic [7:0]          D1_ROT,
    output logic [7:0]          D1_GRUEN,
    output logic [7:0]          D1_BLAU,
    output logic [7:0]          D2_ROT,
    output logic [7:0]          D2_GRUEN,
    output logic [7:0]          D2_BLAU,
    output logic [7:0]          D3_ROT,
    output logic [7:0]          D3_GRUEN,
    output logic [7:0]          D3_BLAU,
    output logic                PENDING
);

    localparam logic [CNT_W-1:0] C_HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    logic       w_gnt_a;
    logic       w_gnt_b;
    logic       w_ack_a;
    logic       w_ack_b;
    logic       w_wr;
    logic       w_commit;
    logic [1:0] w_idx;
    colour_t    w_pay;
    logic       w_apply;
    logic       w_idle;

    colour_t          r_shadow [NUM_LEDS];
    colour_t          r_out    [NUM_LEDS];
    logic [CNT_W-1:0] r_hold;
    logic             r_pending;
    logic             r_apply_due;

    rr_arb2 u_arb (
        .CLK     (CLK),
        .RST     (RST),
        .i_req_a (host.A_REQ),
        .i_req_b (host.B_REQ),
        .o_gnt_a (w_gnt_a),
        .o_gnt_b (w_gnt_b),
        .o_ack_a (w_ack_a),
        .o_ack_b (w_ack_b)
    );

    assign host.A_ACK = w_ack_a;
    assign host.B_ACK = w_ack_b;

    assign w_wr     = w_gnt_a | w_gnt_b;
    assign w_idx    = w_gnt_a ? host.A_IDX : host.B_IDX;
    assign w_pay    = w_gnt_a ? colour_t'{host.A_ROT, host.A_GRUEN, host.A_BLAU}
                              : colour_t'{host.B_ROT, host.B_GRUEN, host.B_BLAU};
    assign w_commit = w_wr & (w_gnt_a ? host.A_COMMIT : host.B_COMMIT);

    // An apply on this edge reloads the timer, so a commit landing now must wait.
    assign w_apply = r_apply_due | (r_pending & (r_hold == '0));
    assign w_idle  = (r_hold == '0) & ~w_apply;

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_wr) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (w_idx == IDX_BCAST || w_idx == 2'(i)) begin
                    r_shadow[i] <= w_pay;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                r_out[i] <= '0;
            end
        end else if (w_apply) begin
            r_out <= r_shadow;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hold      <= '0;
            r_pending   <= 1'b0;
            r_apply_due <= 1'b0;
        end else begin
            if (w_apply) begin
                r_hold <= C_HOLD_LOAD;
            end else if (r_hold != '0) begin
                r_hold <= r_hold - 1'b1;
            end
            r_apply_due <= w_commit & w_idle;
            if (w_commit && !w_idle) begin
                r_pending <= 1'b1;
            end else if (w_apply) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign D1_ROT   = r_out[0].rot;
    assign D1_GRUEN = r_out[0].gruen;
    assign D1_BLAU  = r_out[0].blau;
    assign D2_ROT   = r_out[1].rot;
    assign D2_GRUEN = r_out[1].gruen;
    assign D2_BLAU  = r_out[1].blau;
    assign D3_ROT   = r_out[2].rot;
    assign D3_GRUEN = r_out[2].gruen;
    assign D3_BLAU  = r_out[2].blau;
    assign PENDING  = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_rgb_update_arbiter.sv
`default_nettype none
//============================================================================
// Module : tb_rgb_update_arbiter
// Brief  : Directed bench with an apply scoreboard for rgb_update_arbiter.
// Rev    : 1.0  initial release
//============================================================================
module tb_rgb_update_arbiter;
    import rgb_pkg::*;

    localparam int HOLD  = 16;
    localparam int NEVER = -100000;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    rgb_update_arbiter_if bus ();

    logic [7:0] D1_ROT, D1_GRUEN, D1_BLAU;
    logic [7:0] D2_ROT, D2_GRUEN, D2_BLAU;
    logic [7:0] D3_ROT, D3_GRUEN, D3_BLAU;
    logic       PENDING;
    logic [71:0] outs;

    rgb_update_arbiter #(.HOLD_CYCLES(HOLD)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .host     (bus),
        .D1_ROT   (D1_ROT),
        .D1_GRUEN (D1_GRUEN),
        .D1_BLAU  (D1_BLAU),
        .D2_ROT   (D2_ROT),
        .D2_GRUEN (D2_GRUEN),
        .D2_BLAU  (D2_BLAU),
        .D3_ROT   (D3_ROT),
        .D3_GRUEN (D3_GRUEN),
        .D3_BLAU  (D3_BLAU),
        .PENDING  (PENDING)
    );

    assign outs = {D1_ROT, D1_GRUEN, D1_BLAU, D2_ROT, D2_GRUEN, D2_BLAU,
                   D3_ROT, D3_GRUEN, D3_BLAU};

    typedef struct {
        int          edge_n;
        logic [71:0] data;
    } apply_t;

    apply_t      sb[$];
    logic [23:0] m_shadow [3];
    int          last_apply = NEVER;
    int          cyc        = 0;
    logic        rst_q      = 1'b1;
    int          n_pass     = 0;
    int          n_fail     = 0;
    int          n_total    = 0;
    logic [71:0] prev_outs  = '0;

    always @(posedge CLK) begin
        cyc   <= cyc + 1;
        rst_q <= RST;
    end

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] pack_shadow();
        return {m_shadow[0], m_shadow[1], m_shadow[2]};
    endfunction

    // Apply edge = max(write edge + 1, previous apply + HOLD); earlier-pending applies absorb later writes.
    task automatic sb_write(input int w, input logic [1:0] idx, input logic [23:0] rgb, input bit commit);
        int e;
        for (int i = 0; i < 3; i++) begin
            if (idx == 2'd3 || int'(idx) == i) m_shadow[i] = rgb;
        end
        if (sb.size() > 0 && sb[sb.size()-1].edge_n > w) begin
            sb[sb.size()-1].data = pack_shadow();
        end else if (commit) begin
            e = (w + 1 > last_apply + HOLD) ? w + 1 : last_apply + HOLD;
            sb.push_back('{e, pack_shadow()});
            last_apply = e;
        end
    endtask

    task automatic model_reset();
        sb.delete();
        for (int i = 0; i < 3; i++) m_shadow[i] = '0;
        last_apply = NEVER;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_write(input bit use_b, input logic [1:0] idx, input logic [23:0] rgb,
                            input bit commit, output int lat);
        lat = -1;
        if (!use_b) begin
            bus.A_IDX = idx;
            {bus.A_ROT, bus.A_GRUEN, bus.A_BLAU} = rgb;
            bus.A_COMMIT = commit;
            bus.A_REQ = 1'b1;
        end else begin
            bus.B_IDX = idx;
            {bus.B_ROT, bus.B_GRUEN, bus.B_BLAU} = rgb;
            bus.B_COMMIT = commit;
            bus.B_REQ = 1'b1;
        end
        for (int n = 1; n <= 8; n++) begin
            @(posedge CLK);
            #1;
            if ((!use_b && bus.A_ACK) || (use_b && bus.B_ACK)) begin
                lat = n;
                break;
            end
        end
        if (!use_b) bus.A_REQ = 1'b0;
        else        bus.B_REQ = 1'b0;
        if (lat < 0) check("ack_timeout", 72'(0), 72'(1));
        else         sb_write(cyc, idx, rgb, commit);
    endtask

    task automatic wait_change(input int bound);
        logic [71:0] snap;
        bit          seen;
        snap = outs;
        seen = 1'b0;
        for (int n = 0; n < bound; n++) begin
            tick(1);
            if (outs !== snap) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("change_timeout", 72'(0), 72'(1));
    endtask

    always @(posedge CLK) begin
        apply_t a;
        #2;
        if (!rst_q) begin
            if (outs !== prev_outs) begin
                if (sb.size() == 0) begin
                    check("unexpected_change", outs, prev_outs);
                end else begin
                    a = sb.pop_front();
                    check("apply_edge", 72'(cyc), 72'(a.edge_n));
                    check("apply_data", outs, a.data);
                end
            end else if (sb.size() > 0 && cyc > sb[0].edge_n) begin
                check("missed_apply", 72'(cyc), 72'(sb[0].edge_n));
                void'(sb.pop_front());
            end
        end
        prev_outs = outs;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          p_first;
        int          p_second;
        logic [71:0] snap;

        bus.A_REQ = 0; bus.A_IDX = 0; bus.A_ROT = 0; bus.A_GRUEN = 0; bus.A_BLAU = 0; bus.A_COMMIT = 0;
        bus.B_REQ = 0; bus.B_IDX = 0; bus.B_ROT = 0; bus.B_GRUEN = 0; bus.B_BLAU = 0; bus.B_COMMIT = 0;
        model_reset();
        tick(3);
        check("reset_outs", outs, 72'(0));
        check("reset_pending", 72'(PENDING), 72'(0));
        check("reset_acks", 72'({bus.A_ACK, bus.B_ACK}), 72'(0));
        RST = 1'b0;
        tick(2);

        // Immediate commit from A to D2
        do_write(1'b0, 2'd1, {8'd12, 8'd34, 8'd56}, 1'b1, lat);
        check("a_ack_latency", 72'(lat), 72'(1));
        check("pending_idle", 72'(PENDING), 72'(0));
        tick(1);
        p_first = cyc;
        check("d2_commit", outs, {24'h0, 8'd12, 8'd34, 8'd56, 24'h0});

        // Commit inside the hold window is deferred
        do_write(1'b1, 2'd0, 24'hFF0000, 1'b1, lat);
        check("pending_set", 72'(PENDING), 72'(1));
        wait_change(40);
        check("hold_spacing", 72'(cyc - p_first), 72'(HOLD));
        check("pending_clear", 72'(PENDING), 72'(0));
        check("d1_deferred", 72'(outs[71:48]), 72'(24'hFF0000));

        // Broadcast plus commit merge into one deferred apply
        p_second = cyc;
        do_write(1'b0, 2'd3, 24'h010203, 1'b0, lat);
        do_write(1'b1, 2'd1, 24'h010203, 1'b1, lat);
        check("pending_merge", 72'(PENDING), 72'(1));
        wait_change(40);
        check("bcast_all", outs, {3{24'h010203}});
        check("defer_spacing", 72'(cyc - p_second), 72'(HOLD));
        tick(20);

        // Non-commit traffic never moves the outputs
        snap = outs;
        for (int i = 0; i < 30; i++) begin
            do_write(i[0], 2'($urandom_range(0, 3)), 24'($urandom), 1'b0, lat);
        end
        check("noncommit_stable", outs, snap);
        check("noncommit_pending", 72'(PENDING), 72'(0));

        // Reset during the ACK cycle of a commit
        do_write(1'b0, 2'd2, 24'hAABBCC, 1'b1, lat);
        RST = 1'b1;
        model_reset();
        tick(1);
        RST = 1'b0;
        check("ack_dropped", 72'(bus.A_ACK), 72'(0));
        check("reset_mid_outs", outs, 72'(0));
        check("reset_mid_pending", 72'(PENDING), 72'(0));
        tick(1);
        do_write(1'b0, 2'd0, 24'h445566, 1'b1, lat);
        check("fresh_latency", 72'(lat), 72'(1));
        tick(1);
        check("fresh_apply", outs, {24'h445566, 48'h0});

        // Round-robin with both requesters held
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        model_reset();
        bus.A_IDX = 2'd0; {bus.A_ROT, bus.A_GRUEN, bus.A_BLAU} = 24'h112233; bus.A_COMMIT = 1'b0;
        bus.B_IDX = 2'd1; {bus.B_ROT, bus.B_GRUEN, bus.B_BLAU} = 24'h445566; bus.B_COMMIT = 1'b0;
        bus.A_REQ = 1'b1;
        bus.B_REQ = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            check("rr_ack_a", 72'(bus.A_ACK), 72'(k % 4 == 1));
            check("rr_ack_b", 72'(bus.B_ACK), 72'(k % 4 == 3));
            if (bus.A_ACK) sb_write(cyc, 2'd0, 24'h112233, 1'b0);
            if (bus.B_ACK) sb_write(cyc, 2'd1, 24'h445566, 1'b0);
        end
        bus.A_REQ = 1'b0;
        bus.B_REQ = 1'b0;
        do_write(1'b1, 2'd2, 24'h778899, 1'b1, lat);
        tick(1);
        check("rr_final", outs, {24'h112233, 24'h445566, 24'h778899});

        tick(3);
        check("sb_drain", 72'(sb.size()), 72'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rgb_update_arbiter.md
# rgb_update_arbiter

Front-end controller for the PL9823 three-LED chain driver. Two independent requesters (e.g. status logic and effect generator) write per-LED colours through a req/ack handshake into a shadow buffer. A commit flag publishes the whole buffer atomically onto the driver's nine colour buses. Commits are rate-limited so that at most one visible update lands per driver frame, which prevents tearing and flicker.

## Interface
- HOLD_CYCLES, 9300, minimum cycles between two applies to the output buses; ≥ one full driver frame; 1..16383.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- A_REQ  in  1  requester A write request; held until A_ACK.
- A_IDX  in  2  target LED: 0,1,2 = D1,D2,D3; 3 = broadcast to all three.
- A_ROT / A_GRUEN / A_BLAU  in  8 each  colour payload.
- A_COMMIT  in  1  publish the shadow buffer after this write.
- A_ACK  out  1  one-cycle accept pulse.
- B_REQ, B_IDX, B_ROT, B_GRUEN, B_BLAU, B_COMMIT, B_ACK: same as the A set, for requester B.
- D1_ROT … D3_BLAU  out  8 each  registered colour buses to the driver.
- PENDING  out  1  a commit is waiting for the hold window to expire.

## Operation
- Reset values:
  - All Dn_* outputs, shadow buffer, A_ACK, B_ACK and PENDING = 0.
  - Hold counter = 0 (first commit applies immediately).
  - Round-robin pointer = "B last".
- Arbiter FSM, two states:
  - GRANT: sample A_REQ/B_REQ.
    - Exactly one asserted: that requester wins.
    - Both asserted: the requester not granted last wins.
    - Winner's payload is written to shadow at the clock edge. The pointer updates and the FSM goes to ACKS.
    - No request: stay in GRANT.
  - ACKS: winner's ACK = 1 for this cycle only. No sampling. Return to GRANT.
- Throughput: at most one write per 2 cycles overall. A requester must drop REQ or present new data in the cycle after it sees ACK; a REQ held through ACK is treated as a new request.
- Shadow write:
  - IDX 0..2 overwrites that LED's three bytes.
  - IDX 3 overwrites all nine bytes with the same triple.
- Commit / hold timer:
  - Counter loads HOLD_CYCLES−1 on each apply and decrements to 0.
  - Apply = copy all nine shadow bytes to Dn_* in one cycle.
- Commit write accepted with counter = 0: apply on the cycle after the write (the shadow includes that write). PENDING stays 0.
- Commit write accepted with counter ≠ 0: PENDING = 1.
- Counter reaches 0 with PENDING = 1: apply the current shadow on the next cycle and clear PENDING. Any writes accepted in the meantime, committed or not, are included.
- Further commits while PENDING = 1 merge into the single pending apply.
- Simultaneous events:
  - Commit write at the same edge the counter reaches 0: that write is in the shadow before the apply.
  - Non-commit writes never change Dn_*.
- RST mid-transaction: the in-flight ACK is dropped and the shadow is cleared. Requesters must re-issue.

## Timing
- Write latency: REQ sampled in cycle t; ACK in t+1; shadow updated at the end of t.
- Commit latency, timer idle: Dn_* change in t+2 relative to REQ in t.
- Minimum spacing between two Dn_* changes: exactly HOLD_CYCLES cycles.
- Dn_* are stable between applies; all nine change on the same edge.
- Combinational paths from inputs to outputs: none.

## Structure
- Shared package rgb_pkg:
  - NUM_LEDS = 3.
  - IDX_BCAST = 2'd3.
  - HOLD_DEFAULT = 9300.
  - Colour triple typedef (rot/gruen/blau, 8 bits each).
  - Counter width 14.
- Sub-module rr_arb2: two-requester round-robin with a last-grant pointer and a grant/ack FSM.
- Top level holds the shadow registers, hold timer, PENDING and output registers.

## Test plan
- Reset, then A writes IDX=1, RGB=12/34/56, COMMIT=1 → A_ACK in the next cycle. D2 = 12/34/56 two cycles after REQ. D1 and D3 = 0. PENDING = 0.
- A and B both REQ continuously → grants alternate A, B, A, B. ACKs appear every other cycle, never both at once.
- HOLD_CYCLES=16: commit at t0, then B commits IDX=0 value FF/00/00 at t0+3 → PENDING = 1. D1 changes exactly 16 cycles after the first apply. PENDING clears on that cycle.
- During the hold window: non-commit write IDX=3 = 01/02/03, then a commit → the single deferred apply shows 01/02/03 on all three LEDs. Only one output change occurs.
- Non-commit writes only, for 100 cycles → Dn_* remain unchanged.
- Assert RST in the ACK cycle of a commit write → A_ACK = 0 next cycle. Outputs and shadow = 0, PENDING = 0. A fresh commit afterwards applies immediately.
